// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_arbiter
//  Description : Five-requester round-robin arbiter with a registered one-hot
//                grant and a hold limit. An owner keeps the grant while its
//                request stays high. If other requesters are waiting, it is
//                preempted after MAX_HOLD consecutive grant cycles.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                req[4:0]  - level-sensitive request per agent
//                grant[4:0]- registered one-hot (or zero) grant
//                grant_id  - binary index of the set grant bit, 0 when idle
//                busy      - high iff grant is non-zero
//                timeout   - one-cycle pulse on the first cycle of a grant
//                            that was taken by forced preemption
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic [4:0] r_grant;
    logic [2:0] r_grant_id;
    logic       r_busy;
    logic       r_timeout;

    state_t     w_next_state;
    logic [2:0] w_next_ptr;
    logic [7:0] w_next_hold;
    logic [4:0] w_next_grant;
    logic [2:0] w_next_id;
    logic       w_next_busy;
    logic       w_next_timeout;

    logic [4:0] w_others;
    logic       w_owner_req;
    logic [4:0] w_search_req;
    logic [2:0] w_search_base;
    logic       w_found;
    logic [2:0] w_win;

    // Wraps a sum in the range 0..9 into 0..4.
    function automatic logic [2:0] f_mod5(input logic [3:0] v);
        if (v >= 4'd5) begin
            return 3'(v - 4'd5);
        end
        return v[2:0];
    endfunction

    // While granted, the owner is masked out. This keeps the owner out of
    // the search on preemption. On release, its request is already low.
    assign w_others    = req & ~r_grant;
    assign w_owner_req = |(req & r_grant);

    assign w_search_req  = (r_state == GRANT) ? w_others   : req;
    assign w_search_base = (r_state == GRANT) ? r_grant_id : r_ptr;

    // Round-robin search: the first request at base+1, base+2, ... mod 5.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            if (!w_found && w_search_req[f_mod5({1'b0, w_search_base} + 4'(i))]) begin
                w_found = 1'b1;
                w_win   = f_mod5({1'b0, w_search_base} + 4'(i));
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_ptr     = r_ptr;
        w_next_hold    = r_hold_cnt;
        w_next_grant   = r_grant;
        w_next_id      = r_grant_id;
        w_next_busy    = r_busy;
        w_next_timeout = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_grant = 5'b00001 << w_win;
                    w_next_id    = w_win;
                    w_next_busy  = 1'b1;
                    w_next_hold  = 8'd1;
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_next_ptr = r_grant_id;
                    if (w_found) begin
                        // Hand over directly, so the grant has no zero cycle.
                        w_next_grant = 5'b00001 << w_win;
                        w_next_id    = w_win;
                        w_next_hold  = 8'd1;
                    end else begin
                        w_next_grant = 5'b00000;
                        w_next_id    = 3'd0;
                        w_next_busy  = 1'b0;
                        w_next_hold  = 8'd0;
                        w_next_state = IDLE;
                    end
                end else if (r_hold_cnt == c_max_hold) begin
                    if (w_found) begin
                        w_next_ptr     = r_grant_id;
                        w_next_grant   = 5'b00001 << w_win;
                        w_next_id      = w_win;
                        w_next_hold    = 8'd1;
                        w_next_timeout = 1'b1;
                    end else begin
                        // Nobody else is waiting. Restart the hold window.
                        w_next_hold = 8'd1;
                    end
                end else begin
                    w_next_hold = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 3'd4;
            r_hold_cnt <= 8'd0;
            r_grant    <= 5'b00000;
            r_grant_id <= 3'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= w_next_hold;
            r_grant    <= w_next_grant;
            r_grant_id <= w_next_id;
            r_busy     <= w_next_busy;
            r_timeout  <= w_next_timeout;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_arbiter
//  Description : Directed bench for rr_grant_arbiter with MAX_HOLD = 4. It
//                applies a table of single-cycle vectors, then hand-written
//                sequences for contention, a sole requester and an
//                asynchronous reset in the middle of a grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int c_hold = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_checks;
    int n_errors;

    rr_grant_arbiter #(
        .MAX_HOLD (c_hold)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] id;
        logic       to;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [4:0] eg,
                         input logic [2:0] eid, input logic eto);
        logic eb;
        eb = (eg != 5'b00000);
        n_checks++;
        if (grant !== eg || grant_id !== eid || busy !== eb || timeout !== eto) begin
            n_errors++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
                     name, grant, grant_id, busy, timeout, eg, eid, eb, eto);
        end
    endtask

    // Drive req away from the active edge, then sample just after the edge.
    task automatic step(input logic [4:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] eg;
        int         idx;

        n_checks = 0;
        n_errors = 0;
        req      = 5'b00000;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_assert", 5'b00000, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset idle: no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step(5'b00000);
            check($sformatf("reset_idle_%0d", i), 5'b00000, 3'd0, 1'b0);
        end

        // Single-cycle vectors. Pointer starts at 4 and MAX_HOLD is 4.
        vecs[0]  = '{5'b00001, 5'b00001, 3'd0, 1'b0}; // first grant from ptr 4
        vecs[1]  = '{5'b00000, 5'b00000, 3'd0, 1'b0}; // release to idle, ptr 0
        vecs[2]  = '{5'b00100, 5'b00100, 3'd2, 1'b0}; // scan 1,2 -> 2
        vecs[3]  = '{5'b10101, 5'b00100, 3'd2, 1'b0}; // owner holds (hold 2)
        vecs[4]  = '{5'b10001, 5'b10000, 3'd4, 1'b0}; // owner 2 drops: 3,4 -> 4
        vecs[5]  = '{5'b10001, 5'b10000, 3'd4, 1'b0}; // hold 2
        vecs[6]  = '{5'b10001, 5'b10000, 3'd4, 1'b0}; // hold 3
        vecs[7]  = '{5'b10001, 5'b10000, 3'd4, 1'b0}; // hold 4
        vecs[8]  = '{5'b10001, 5'b00001, 3'd0, 1'b1}; // preempt, wrap 4 -> 0
        vecs[9]  = '{5'b00001, 5'b00001, 3'd0, 1'b0}; // pulse lasts one cycle
        vecs[10] = '{5'b00010, 5'b00010, 3'd1, 1'b0}; // release and switch, no bubble
        vecs[11] = '{5'b00000, 5'b00000, 3'd0, 1'b0}; // release to idle, ptr 1
        vecs[12] = '{5'b10001, 5'b10000, 3'd4, 1'b0}; // idle scan 2,3,4 -> 4
        vecs[13] = '{5'b00000, 5'b00000, 3'd0, 1'b0}; // idle again, ptr 4

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].req);
            check($sformatf("vec_%0d", i), vecs[i].grant, vecs[i].id, vecs[i].to);
        end

        // Full contention: each owner gets exactly 4 cycles, rotating 0..4.
        for (int c = 0; c < 24; c++) begin
            step(5'b11111);
            idx = (c / c_hold) % 5;
            eg  = 5'b00001 << idx;
            check($sformatf("contention_%0d", c), eg, 3'(idx),
                  (c > 0) && (c % c_hold == 0));
        end
        step(5'b00000);
        check("contention_release", 5'b00000, 3'd0, 1'b0);

        // Sole requester, where ptr is 0: grant is held and never times out.
        for (int c = 0; c < 3 * c_hold; c++) begin
            step(5'b01000);
            check($sformatf("sole_%0d", c), 5'b01000, 3'd3, 1'b0);
        end

        // Owner 3 drops while 2 requests: scan 4,0,1,2 -> 2 directly.
        step(5'b00100);
        check("switch_to_2", 5'b00100, 3'd2, 1'b0);

        // Asynchronous reset between edges while grant is 00100.
        @(negedge clk);
        req = 5'b11111;
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", 5'b00000, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_grant", 5'b00001, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
